// File: rtl/pll_reconfig_if.sv
// Signal bundle between the system control logic, the PLL reconfig sequencer
// and the reconfig IP management port. master = sequencer side.
interface pll_reconfig_if;
    logic        req;
    logic        req_sel;
    logic        busy;
    logic        done;
    logic        error;
    logic        cur_profile;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        input  req, req_sel, pll_locked, mgmt_waitrequest,
        output busy, done, error, cur_profile, mgmt_address, mgmt_write, mgmt_writedata
    );

    modport slave (
        output req, req_sel, pll_locked, mgmt_waitrequest,
        input  busy, done, error, cur_profile, mgmt_address, mgmt_write, mgmt_writedata
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// Sequences mode/M/C/start writes to the PLL reconfig IP to switch between two
// frequency profiles, then waits for a stable synchronized lock or times out.
module pll_reconfig_ctrl #(
    parameter logic [31:0] PROF0_M     = 32'h0000_0808,
    parameter logic [31:0] PROF0_C     = 32'h0000_0C0C,
    parameter logic [31:0] PROF1_M     = 32'h0000_0909,
    parameter logic [31:0] PROF1_C     = 32'h0000_0B0B,
    parameter logic [5:0]  ADDR_MODE   = 6'd0,
    parameter logic [5:0]  ADDR_START  = 6'd2,
    parameter logic [5:0]  ADDR_M      = 6'd4,
    parameter logic [5:0]  ADDR_C      = 6'd5,
    parameter int          LOCK_CYCLES = 16,
    parameter int          TIMEOUT     = 65535
) (
    input logic            clk,
    input logic            rst_n,
    pll_reconfig_if.master bus
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0] LOCK_TGT = LCW'(LOCK_CYCLES);
    localparam logic [15:0]    TO_TGT   = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_MODE   = 3'd1,
        WR_M      = 3'd2,
        WR_C      = 3'd3,
        WR_START  = 3'd4,
        WAIT_LOCK = 3'd5
    } state_t;

    state_t         state_r, state_s;
    logic           sel_r, sel_s;
    logic           busy_r, busy_s;
    logic           done_r, done_s;
    logic           error_r, error_s;
    logic           cur_r, cur_s;
    logic           write_r, write_s;
    logic [5:0]     addr_r, addr_s;
    logic [31:0]    data_r, data_s;
    logic [LCW-1:0] lock_cnt_r, lock_cnt_s;
    logic [15:0]    to_cnt_r, to_cnt_s;
    logic           sync1_r;
    logic           lock_sync_r;

    function automatic logic [31:0] prof_word(input logic sel, input logic c_reg);
        logic [31:0] w;
        if (c_reg) begin
            w = sel ? PROF1_C : PROF0_C;
        end else begin
            w = sel ? PROF1_M : PROF0_M;
        end
        return w;
    endfunction

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r     <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            sync1_r     <= bus.pll_locked;
            lock_sync_r <= sync1_r;
        end
    end

    // Next-state and next-output logic for the sequencer
    always_comb begin
        state_s    = state_r;
        sel_s      = sel_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        error_s    = 1'b0;
        cur_s      = cur_r;
        write_s    = write_r;
        addr_s     = addr_r;
        data_s     = data_r;
        lock_cnt_s = lock_cnt_r;
        to_cnt_s   = to_cnt_r;
        case (state_r)
            IDLE: begin
                if (bus.req) begin
                    state_s = WR_MODE;
                    sel_s   = bus.req_sel;
                    busy_s  = 1'b1;
                    write_s = 1'b1;
                    addr_s  = ADDR_MODE;
                    data_s  = 32'd0;
                end else begin
                    write_s = 1'b0;
                end
            end
            WR_MODE, WR_M, WR_C, WR_START: begin
                // Strobe low inside a write state means the write was accepted last edge
                if (write_r) begin
                    if (!bus.mgmt_waitrequest) begin
                        write_s = 1'b0;
                    end else begin
                        write_s = 1'b1;
                    end
                end else begin
                    case (state_r)
                        WR_MODE: begin
                            state_s = WR_M;
                            write_s = 1'b1;
                            addr_s  = ADDR_M;
                            data_s  = prof_word(sel_r, 1'b0);
                        end
                        WR_M: begin
                            state_s = WR_C;
                            write_s = 1'b1;
                            addr_s  = ADDR_C;
                            data_s  = prof_word(sel_r, 1'b1);
                        end
                        WR_C: begin
                            state_s = WR_START;
                            write_s = 1'b1;
                            addr_s  = ADDR_START;
                            data_s  = 32'd1;
                        end
                        WR_START: begin
                            state_s    = WAIT_LOCK;
                            lock_cnt_s = '0;
                            to_cnt_s   = 16'd0;
                        end
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end
            end
            WAIT_LOCK: begin
                lock_cnt_s = lock_sync_r ? (lock_cnt_r + LCW'(1)) : '0;
                to_cnt_s   = to_cnt_r + 16'd1;
                // Lock success takes priority over a simultaneous timeout
                if (lock_cnt_r == LOCK_TGT) begin
                    done_s  = 1'b1;
                    cur_s   = sel_r;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else if (to_cnt_r == TO_TGT) begin
                    error_s = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                write_s = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sel_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            cur_r      <= 1'b0;
            write_r    <= 1'b0;
            addr_r     <= 6'd0;
            data_r     <= 32'd0;
            lock_cnt_r <= '0;
            to_cnt_r   <= 16'd0;
        end else begin
            state_r    <= state_s;
            sel_r      <= sel_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
            cur_r      <= cur_s;
            write_r    <= write_s;
            addr_r     <= addr_s;
            data_r     <= data_s;
            lock_cnt_r <= lock_cnt_s;
            to_cnt_r   <= to_cnt_s;
        end
    end

    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.error          = error_r;
    assign bus.cur_profile    = cur_r;
    assign bus.mgmt_write     = write_r;
    assign bus.mgmt_address   = addr_r;
    assign bus.mgmt_writedata = data_r;

endmodule
